// File: rtl/scan_mem_reg_resp_if.sv
// Scan access bus plus memory port bundle for scan_mem_reg_resp.
// slave  : the responder (scan_mem_reg_resp) view.
// master : the environment view (scan request controller and memory side).
interface scan_mem_reg_resp_if;
  // scan request / response
  logic        scan_wen;
  logic        scan_ren;
  logic [13:0] scan_addr;
  logic [31:0] scan_wdata;
  logic [31:0] scan_rdata;
  logic        scan_ready;
  // variable-latency memory port
  logic        mem_req;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport slave (
    input  scan_wen, scan_ren, scan_addr, scan_wdata,
    output scan_rdata, scan_ready,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport master (
    output scan_wen, scan_ren, scan_addr, scan_wdata,
    input  scan_rdata, scan_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/scan_mem_reg_resp.sv
// scan_mem_reg_resp: responder end of the scan access path.
// Decodes a 14-bit scan address into a local 32-bit register bank
// (addr[13]=0) or a variable-latency memory port (addr[13]=1) and returns
// exactly one scan_ready pulse per accepted request. Requests that arrive
// while a transaction (or its ready pulse) is in flight are dropped and
// flagged in the sticky err_drop.
// Optional feature: define SCAN_RESP_TIMEOUT_EN to add a memory
// transaction timeout (TIMEOUT cycles, reply 32'hDEAD_BEEF on reads).
module scan_mem_reg_resp #(
  parameter int NREG    = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  scan_mem_reg_resp_if.slave   bus,
  input  logic                 i_err_clr,
  output logic [NREG*32-1:0]   o_reg_q,
  output logic                 o_err_drop,
  output logic                 o_err_timeout
);

  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REG_RESP = 2'd1,
    MEM_REQ  = 2'd2,
    MEM_WAIT = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_ready;
  logic [31:0] r_rdata;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [12:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_err_drop;

  logic        w_req;
  logic        w_accept;
  logic        w_drop;
  logic [31:0] w_off;
  logic        w_in_range;
  logic [IW-1:0] w_idx;
  logic        w_reg_we;
  logic [31:0] w_reg_rd;
  logic [31:0] w_regs [NREG];
  logic        w_to_fire;

  // A request is only taken in IDLE and not during the cycle the previous
  // ready pulse is out (memory completions return straight to IDLE).
  assign w_req      = bus.scan_wen | bus.scan_ren;
  assign w_accept   = w_req && (r_state == IDLE) && !r_ready;
  assign w_drop     = w_req && !w_accept;
  assign w_off      = {19'd0, bus.scan_addr[12:0]};
  assign w_in_range = (w_off < 32'(NREG));
  assign w_idx      = bus.scan_addr[IW-1:0];
  assign w_reg_we   = w_accept && bus.scan_wen && !bus.scan_addr[13] && w_in_range;
  assign w_reg_rd   = w_in_range ? w_regs[w_idx] : 32'd0;

  // Register bank: one flop row per register, exported flat on o_reg_q.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      logic [31:0] r_q;
      // Register gi takes the write data when an in-range write hits it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q <= 32'd0;
        end else if (w_reg_we && (w_idx == IW'(gi))) begin
          r_q <= bus.scan_wdata;
        end
      end
      assign w_regs[gi]             = r_q;
      assign o_reg_q[gi*32 +: 32]   = r_q;
    end
  endgenerate

`ifdef SCAN_RESP_TIMEOUT_EN
  logic [15:0] r_cnt;
  logic        r_err_timeout;
  logic        w_to_hit;

  // The count reaches TIMEOUT at the edge where it would step past TIMEOUT-1;
  // a grant/rvalid in that same cycle takes precedence over the timeout.
  assign w_to_hit  = (r_cnt == 16'(TIMEOUT - 1));
  assign w_to_fire = w_to_hit &&
                     (((r_state == MEM_REQ)  && !bus.mem_gnt) ||
                      ((r_state == MEM_WAIT) && !bus.mem_rvalid));

  // Cycle counter for the current memory transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 16'd0;
    end else if (w_accept && bus.scan_addr[13]) begin
      r_cnt <= 16'd0;
    end else if ((r_state == MEM_REQ) || (r_state == MEM_WAIT)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Sticky timeout flag; a set beats a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_timeout <= 1'b0;
    end else if (w_to_fire) begin
      r_err_timeout <= 1'b1;
    end else if (i_err_clr) begin
      r_err_timeout <= 1'b0;
    end
  end

  assign o_err_timeout = r_err_timeout;
`else
  assign w_to_fire     = 1'b0;
  assign o_err_timeout = 1'b0;
`endif

  // Main FSM: accepts requests, drives the memory port, produces ready/rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ready     <= 1'b0;
      r_rdata     <= 32'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 13'd0;
      r_mem_wdata <= 32'd0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (!bus.scan_addr[13]) begin
              // Register access completes in one cycle.
              r_state <= REG_RESP;
              r_ready <= 1'b1;
              if (!bus.scan_wen) begin
                r_rdata <= w_reg_rd;
              end
            end else begin
              r_state     <= MEM_REQ;
              r_mem_req   <= 1'b1;
              r_mem_we    <= bus.scan_wen;
              r_mem_addr  <= bus.scan_addr[12:0];
              r_mem_wdata <= bus.scan_wdata;
            end
          end
        end
        REG_RESP: begin
          r_state <= IDLE;
        end
        MEM_REQ: begin
          if (bus.mem_gnt) begin
            r_mem_req <= 1'b0;
            if (r_mem_we) begin
              r_ready <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_state <= MEM_WAIT;
            end
          end else if (w_to_fire) begin
            r_mem_req <= 1'b0;
            r_ready   <= 1'b1;
            r_state   <= IDLE;
            if (!r_mem_we) begin
              r_rdata <= 32'hDEAD_BEEF;
            end
          end
        end
        MEM_WAIT: begin
          if (bus.mem_rvalid) begin
            r_rdata <= bus.mem_rdata;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end else if (w_to_fire) begin
            r_rdata <= 32'hDEAD_BEEF;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Sticky drop flag; a set beats a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_drop <= 1'b0;
    end else if (w_drop) begin
      r_err_drop <= 1'b1;
    end else if (i_err_clr) begin
      r_err_drop <= 1'b0;
    end
  end

  assign bus.scan_ready = r_ready;
  assign bus.scan_rdata = r_rdata;
  assign bus.mem_req    = r_mem_req;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign o_err_drop     = r_err_drop;

endmodule

// File: tb/tb_scan_mem_reg_resp.sv
// Directed, table-driven bench for scan_mem_reg_resp.
// Timeout checks are compiled in when SCAN_RESP_TIMEOUT_EN is defined.
module tb_scan_mem_reg_resp;
  localparam int NREG = 16;
`ifdef SCAN_RESP_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               err_clr = 1'b0;
  logic [NREG*32-1:0] reg_q;
  logic               err_drop;
  logic               err_timeout;

  scan_mem_reg_resp_if bus();

  scan_mem_reg_resp #(.NREG(NREG), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .i_err_clr     (err_clr),
    .o_reg_q       (reg_q),
    .o_err_drop    (err_drop),
    .o_err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.scan_wen   = 1'b0;
    bus.scan_ren   = 1'b0;
    bus.scan_addr  = 14'd0;
    bus.scan_wdata = 32'd0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'd0;
  endtask

  typedef struct {
    logic        wen;
    logic        ren;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          ri;
    logic [31:0] rv;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int ready_seen;
    // register-bank vectors: {wen, ren, addr, wdata, expected rdata, reg idx, expected reg}
    vecs[0] = '{1'b0, 1'b1, 14'h0003, 32'h0,         32'h0,         3,  32'h0};
    vecs[1] = '{1'b1, 1'b0, 14'h0005, 32'h1234_5678, 32'h0,         5,  32'h1234_5678};
    vecs[2] = '{1'b0, 1'b1, 14'h0005, 32'h0,         32'h1234_5678, 5,  32'h1234_5678};
    vecs[3] = '{1'b0, 1'b1, 14'h0010, 32'h0,         32'h0,         2,  32'h0};
    vecs[4] = '{1'b1, 1'b1, 14'h0002, 32'hA5A5_A5A5, 32'h0,         2,  32'hA5A5_A5A5};
    vecs[5] = '{1'b0, 1'b1, 14'h0002, 32'h0,         32'hA5A5_A5A5, 2,  32'hA5A5_A5A5};
    vecs[6] = '{1'b1, 1'b0, 14'h000F, 32'hFFFF_0001, 32'hA5A5_A5A5, 15, 32'hFFFF_0001};
    vecs[7] = '{1'b1, 1'b0, 14'h0010, 32'h1111_1111, 32'hA5A5_A5A5, 0,  32'h0};
    vecs[8] = '{1'b0, 1'b1, 14'h000F, 32'h0,         32'hFFFF_0001, 15, 32'hFFFF_0001};
    vecs[9] = '{1'b0, 1'b1, 14'h1FFF, 32'h0,         32'h0,         5,  32'h1234_5678};

    clear_in();
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst scan_ready",  32'(bus.scan_ready), 32'd0);
    chk("rst scan_rdata",  bus.scan_rdata,      32'd0);
    chk("rst mem_req",     32'(bus.mem_req),    32'd0);
    chk("rst mem_we",      32'(bus.mem_we),     32'd0);
    chk("rst mem_addr",    32'(bus.mem_addr),   32'd0);
    chk("rst mem_wdata",   bus.mem_wdata,       32'd0);
    chk("rst reg_q nz",    32'(reg_q != '0),    32'd0);
    chk("rst err_drop",    32'(err_drop),       32'd0);
    chk("rst err_timeout", 32'(err_timeout),    32'd0);
    rst_n = 1'b1;
    step();

    // table-driven register accesses
    for (int i = 0; i < 10; i++) begin
      bus.scan_wen   = vecs[i].wen;
      bus.scan_ren   = vecs[i].ren;
      bus.scan_addr  = vecs[i].addr;
      bus.scan_wdata = vecs[i].wdata;
      step();
      clear_in();
      chk($sformatf("vec%0d ready", i), 32'(bus.scan_ready), 32'd1);
      chk($sformatf("vec%0d rdata", i), bus.scan_rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d reg%0d", i, vecs[i].ri), reg_q[vecs[i].ri*32 +: 32], vecs[i].rv);
      $display("txn vec%0d wen=%0b ren=%0b addr=0x%04h wdata=0x%08h rdata=0x%08h",
               i, vecs[i].wen, vecs[i].ren, vecs[i].addr, vecs[i].wdata, bus.scan_rdata);
      step();
      chk($sformatf("vec%0d ready low", i), 32'(bus.scan_ready), 32'd0);
    end

    // memory read with delayed grant, busy drop during MEM_WAIT
    bus.scan_ren = 1'b1; bus.scan_addr = 14'h2040;
    step(); clear_in();
    chk("mrd req",    32'(bus.mem_req),    32'd1);
    chk("mrd we",     32'(bus.mem_we),     32'd0);
    chk("mrd addr",   32'(bus.mem_addr),   32'h40);
    chk("mrd ready0", 32'(bus.scan_ready), 32'd0);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;  // ignored outside MEM_WAIT
    step(); clear_in();
    chk("mrd req hold", 32'(bus.mem_req),  32'd1);
    chk("mrd addr hold", 32'(bus.mem_addr), 32'h40);
    bus.mem_gnt = 1'b1;
    step(); clear_in();
    chk("mrd req after gnt", 32'(bus.mem_req),    32'd0);
    chk("mrd no early ready", 32'(bus.scan_ready), 32'd0);
    bus.scan_ren = 1'b1; bus.scan_addr = 14'h0003;
    step(); clear_in();
    chk("drop flag", 32'(err_drop), 32'd1);
    chk("drop no ready", 32'(bus.scan_ready), 32'd0);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    step(); clear_in();
    chk("mrd ready", 32'(bus.scan_ready), 32'd1);
    chk("mrd rdata", bus.scan_rdata, 32'hCAFE_F00D);
    $display("txn mem read addr=0x2040 rdata=0x%08h", bus.scan_rdata);
    step();
    chk("mrd ready low", 32'(bus.scan_ready), 32'd0);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0BAD_F00D;
    step(); clear_in();
    chk("idle rvalid ignored", bus.scan_rdata, 32'hCAFE_F00D);
    chk("idle rvalid no ready", 32'(bus.scan_ready), 32'd0);
    err_clr = 1'b1;
    step(); err_clr = 1'b0;
    chk("err_clr", 32'(err_drop), 32'd0);

    // memory write, immediate grant; request during the ready cycle is dropped
    bus.scan_wen = 1'b1; bus.scan_addr = 14'h3FFF; bus.scan_wdata = 32'hDEAD_C0DE;
    step(); clear_in();
    chk("mwr req",   32'(bus.mem_req),  32'd1);
    chk("mwr we",    32'(bus.mem_we),   32'd1);
    chk("mwr addr",  32'(bus.mem_addr), 32'h1FFF);
    chk("mwr wdata", bus.mem_wdata,     32'hDEAD_C0DE);
    bus.mem_gnt = 1'b1;
    step(); clear_in();
    chk("mwr ready",   32'(bus.scan_ready), 32'd1);
    chk("mwr req low", 32'(bus.mem_req),    32'd0);
    chk("mwr rdata kept", bus.scan_rdata,   32'hCAFE_F00D);
    $display("txn mem write addr=0x3FFF wdata=0xDEADC0DE");
    bus.scan_ren = 1'b1; bus.scan_addr = 14'h0005; err_clr = 1'b1;
    step(); clear_in(); err_clr = 1'b0;
    chk("ready-cycle drop no ready", 32'(bus.scan_ready), 32'd0);
    chk("set beats clr", 32'(err_drop), 32'd1);
    step();
    chk("ready-cycle drop still none", 32'(bus.scan_ready), 32'd0);
    err_clr = 1'b1;
    step(); err_clr = 1'b0;
    chk("err_clr 2", 32'(err_drop), 32'd0);

`ifdef SCAN_RESP_TIMEOUT_EN
    // timeout: no grant ever arrives
    bus.scan_ren = 1'b1; bus.scan_addr = 14'h2000;
    step(); clear_in();
    for (int k = 0; k < TO; k++) begin
      chk($sformatf("to wait%0d {ready,req}", k), {30'd0, bus.scan_ready, bus.mem_req}, 32'd1);
      step();
    end
    chk("to ready",   32'(bus.scan_ready), 32'd1);
    chk("to rdata",   bus.scan_rdata,      32'hDEAD_BEEF);
    chk("to flag",    32'(err_timeout),    32'd1);
    chk("to req low", 32'(bus.mem_req),    32'd0);
    $display("txn mem read timeout addr=0x2000 rdata=0x%08h", bus.scan_rdata);
    step();
    chk("to ready low", 32'(bus.scan_ready), 32'd0);
`endif

    // asynchronous reset in the middle of a memory read
    bus.scan_ren = 1'b1; bus.scan_addr = 14'h2000;
    step(); clear_in();
    step();
    chk("mid req before rst", 32'(bus.mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid rst mem_req",  32'(bus.mem_req),    32'd0);
    chk("mid rst rdata",    bus.scan_rdata,      32'd0);
    chk("mid rst reg_q nz", 32'(reg_q != '0),    32'd0);
    chk("mid rst err_drop", 32'(err_drop),       32'd0);
    chk("mid rst err_to",   32'(err_timeout),    32'd0);
    step();
    rst_n = 1'b1;
    ready_seen = 0;
    bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h5555_AAAA;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus.scan_ready) ready_seen++;
    end
    clear_in();
    chk("no ready after rst", 32'(ready_seen), 32'd0);
    chk("rdata after rst",    bus.scan_rdata,  32'd0);
    $display("txn reset mid-transaction, ready pulses seen=%0d", ready_seen);
    bus.scan_ren = 1'b1; bus.scan_addr = 14'h0005;
    step(); clear_in();
    chk("post-rst read ready", 32'(bus.scan_ready), 32'd1);
    chk("post-rst read rdata", bus.scan_rdata,      32'd0);
    step();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/scan_mem_reg_resp.md
# scan_mem_reg_resp

Responder end of the scan access path in the group_scan_mem_reg_if subsystem. It accepts the single-cycle scan_wen/scan_ren request pulses from the scan request controller and decodes the 14-bit scan address into a local 32-bit register bank or a variable-latency memory port. It returns exactly one scan_ready pulse per accepted request, with read data on scan_rdata. Requests that arrive while a transaction is in flight are dropped and flagged.

## Interface
- NREG, 16: number of 32-bit registers in the bank, 1..256.
- TIMEOUT, 255: cycle limit for a memory transaction, 1..65535; used only with the timeout feature.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- scan_wen  in  1  write request pulse.
- scan_ren  in  1  read request pulse.
- scan_addr  in  14  [13]=0 register bank, [13]=1 memory; [12:0] offset.
- scan_wdata  in  32  write data, valid with scan_wen.
- scan_rdata  out  32  read data, valid while scan_ready=1, then held.
- scan_ready  out  1  one-cycle completion pulse.
- mem_req  out  1  memory request, held until mem_gnt.
- mem_we  out  1  1=write, stable while mem_req=1.
- mem_addr  out  13  memory word address.
- mem_wdata  out  32  memory write data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data.
- reg_q  out  NREG*32  flat register bank contents; reg i is at [32i+31:32i].
- err_drop  out  1  sticky: a request arrived while busy.
- err_timeout  out  1  sticky: a memory transaction timed out. Constant 0 when the feature is compiled out.
- err_clr  in  1  clears both sticky flags. It loses against a set in the same cycle.

## Operation
- FSM states: IDLE, REG_RESP, MEM_REQ, MEM_WAIT.
- IDLE: a request is scan_wen|scan_ren. A request with scan_wen=1 is a write; scan_ren is ignored in that case.
  - Capture scan_addr, scan_wdata and the direction.
  - addr[13]=0 → REG_RESP. addr[13]=1 → MEM_REQ, with mem_req=1 on the next cycle.
- REG_RESP:
  - Write to offset < NREG updates the register. Write to offset ≥ NREG is discarded.
  - Read returns the register, or 0 if offset ≥ NREG.
  - Pulse scan_ready, then return to IDLE.
- MEM_REQ: hold mem_req, mem_we, mem_addr and mem_wdata until mem_gnt=1.
  - Write with grant → pulse scan_ready next cycle, then IDLE.
  - Read with grant → MEM_WAIT. mem_rvalid is ignored outside MEM_WAIT.
- MEM_WAIT: on mem_rvalid, latch mem_rdata to scan_rdata, pulse scan_ready next cycle, then IDLE.
- Any request in a non-IDLE state (including the cycle scan_ready pulses) is dropped: no response, err_drop←1.
- scan_rdata changes only on a read completion. Writes leave it unchanged.
- Reset, including mid-transaction, returns the FSM to IDLE and sets all outputs and registers to 0:
  - scan_ready, scan_rdata, mem_req, mem_we, mem_addr, mem_wdata, reg_q, err_drop, err_timeout.
  - No pending ready pulse survives reset.

## Timing
- All outputs are registered.
- Register access: request sampled at edge T → scan_ready=1 in cycle T+1 (1-cycle latency). The next request is accepted from T+2.
- Memory write: mem_req=1 from T+1. mem_gnt at cycle G → scan_ready=1 in G+1, mem_req=0 in G+1.
- Memory read: mem_gnt at cycle G; mem_rvalid at cycle V>G → scan_ready and scan_rdata in V+1.
- Minimum memory latency: 2 cycles for writes, 3 for reads (gnt at T+1, rvalid at T+2).
- scan_ready is never high for two consecutive cycles.

## Configuration
- SCAN_RESP_TIMEOUT_EN defined:
  - A 16-bit counter clears on entering MEM_REQ and increments each cycle in MEM_REQ/MEM_WAIT.
  - When the count reaches TIMEOUT: mem_req←0, go to IDLE, pulse scan_ready, err_timeout←1.
  - A timed-out read returns scan_rdata=32'hDEAD_BEEF.
  - If mem_gnt or mem_rvalid coincides with the timeout cycle, the normal completion wins.
- Undefined: no counter; a memory transaction waits indefinitely; err_timeout is tied to 0.

## Test plan
- Reset values: hold rst_n=0 → all outputs 0. Release, then read addr 0x0003 → scan_rdata=0, scan_ready pulses at T+1.
- Register write/read: write 0x1234_5678 to 0x0005, then read 0x0005 → scan_rdata=0x1234_5678 at T+1 and reg_q[191:160]=0x1234_5678. Read 0x0010 with NREG=16 → 0.
- Memory read: read 0x2040, memory grants after 3 cycles and gives rvalid 2 cycles later with 0xCAFE_F00D.
  - Required: mem_addr=0x0040 and mem_we=0 while mem_req=1.
  - Required: scan_ready with 0xCAFE_F00D exactly one cycle after rvalid.
- Busy drop: issue a second read during MEM_WAIT → it gets no scan_ready and err_drop=1. err_clr then drives err_drop to 0.
- Simultaneous wen+ren to 0x0002 with data 0xA5A5_A5A5 → treated as a write: reg 2 = 0xA5A5_A5A5, scan_rdata unchanged.
- Timeout (SCAN_RESP_TIMEOUT_EN, TIMEOUT=8): read 0x2000 with mem_gnt held 0 → scan_ready after 8 cycles, scan_rdata=0xDEAD_BEEF, err_timeout=1, mem_req=0. Assert rst_n mid-wait in a repeat run → immediate IDLE and no ready pulse.
